// File: rtl/core_pkg.sv
// Shared core types and constants.
// Register index type and register-file size.
package core_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/core_scoreboard_if.sv
// Scoreboard bundle: issue handshake, retire/squash
// reports, flush and status outputs.
interface core_scoreboard_if;
  import core_pkg::*;

  logic        issue_valid;
  logic        issue_ready;
  reg_idx_t    issue_rs1;
  reg_idx_t    issue_rs2;
  logic        issue_rs1_used;
  logic        issue_rs2_used;
  reg_idx_t    issue_rd;
  logic        issue_rd_we;
  logic        retire_valid;
  reg_idx_t    retire_rd;
  logic        squash_valid;
  reg_idx_t    squash_rd;
  logic        flush_all;
  logic [31:0] busy;
  logic        idle;
  logic [31:0] stall_cycles;
  logic        underflow_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2,
    output issue_rs1_used, issue_rs2_used,
    output issue_rd, issue_rd_we,
    output retire_valid, retire_rd,
    output squash_valid, squash_rd,
    output flush_all,
    input  issue_ready, busy, idle,
    input  stall_cycles, underflow_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2,
    input  issue_rs1_used, issue_rs2_used,
    input  issue_rd, issue_rd_we,
    input  retire_valid, retire_rd,
    input  squash_valid, squash_rd,
    input  flush_all,
    output issue_ready, busy, idle,
    output stall_cycles, underflow_err
  );

endinterface

// File: rtl/core_scoreboard_cnt.sv
// One register's in-flight write counter.
// Up/down with clamp at 0 and MAX_PENDING.
module core_scoreboard_cnt #(
  parameter int MAX_PENDING = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec_r,
  input  logic dec_s,
  input  logic clr,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   ext_t;

  cnt_t cnt_q;
  cnt_t cnt_d;
  ext_t up;
  ext_t dn;

  // Next count: clear wins, else add/sub with clamping.
  always_comb begin
    up        = {1'b0, cnt_q} + ext_t'(inc);
    dn        = ext_t'(dec_r) + ext_t'(dec_s);
    underflow = 1'b0;
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (dn > up) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end else if ((up - dn) > ext_t'(MAX_PENDING)) begin
      cnt_d = cnt_t'(MAX_PENDING);
    end else begin
      cnt_d = cnt_t'(up - dn);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == cnt_t'(MAX_PENDING));

endmodule

// File: rtl/core_scoreboard.sv
// Register scoreboard and issue-stall controller.
// Gates issue on RAW hazards and per-rd saturation.
module core_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic            clk,
  input  logic            rst,
  core_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] uf;
  logic                ready;
  logic                fire;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                waw_sat;
  logic [31:0]         stall_q;
  logic                uf_q;

  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;
  assign uf[0]   = 1'b0;

  // Issue gating from registered counts only.
  always_comb begin
    rs1_haz = sb.issue_rs1_used
           && (sb.issue_rs1 != '0)
           && nz[sb.issue_rs1];
    rs2_haz = sb.issue_rs2_used
           && (sb.issue_rs2 != '0)
           && nz[sb.issue_rs2];
    waw_sat = sb.issue_rd_we
           && (sb.issue_rd != '0)
           && full[sb.issue_rd];
    ready   = !sb.flush_all
           && !(rs1_haz || rs2_haz || waw_sat);
  end

  assign fire = sb.issue_valid && ready;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    core_scoreboard_cnt #(
      .MAX_PENDING(MAX_PENDING)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (fire && sb.issue_rd_we
                 && (sb.issue_rd == reg_idx_t'(i))),
      .dec_r    (sb.retire_valid
                 && (sb.retire_rd == reg_idx_t'(i))),
      .dec_s    (sb.squash_valid
                 && (sb.squash_rd == reg_idx_t'(i))),
      .clr      (sb.flush_all),
      .nonzero  (nz[i]),
      .full     (full[i]),
      .underflow(uf[i])
    );
  end

  // Saturating stall counter and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      if (sb.issue_valid && !ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (|uf)
        uf_q <= 1'b1;
    end
  end

  assign sb.issue_ready   = ready;
  assign sb.busy          = nz;
  assign sb.idle          = ~|nz;
  assign sb.stall_cycles  = stall_q;
  assign sb.underflow_err = uf_q;

endmodule

// File: doc/core_scoreboard.md
# core_scoreboard

Register scoreboard and issue-stall controller for the in-order LETC core pipeline. Tracks outstanding writes to each architectural integer register, from issue in decode to writeback or squash. Gates instruction issue on RAW hazards and on per-register in-flight saturation. Sits beside the decode stage; writeback and the flush logic report completions and squashes to it.

## Interface
- `MAX_PENDING`, default 3: maximum in-flight writes to one register; counter width is CW = $clog2(MAX_PENDING+1).
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  decode has an instruction to issue
- `issue_ready`  out  1  scoreboard permits issue; handshake fires when valid && ready
- `issue_rs1`, `issue_rs2`  in  reg_idx_t  source register indices
- `issue_rs1_used`, `issue_rs2_used`  in  1  source actually read (format-dependent)
- `issue_rd`  in  reg_idx_t  destination index
- `issue_rd_we`  in  1  instruction writes rd
- `retire_valid`  in  1  writeback committed a write
- `retire_rd`  in  reg_idx_t  its rd
- `squash_valid`  in  1  an issued rd-writing instruction was killed
- `squash_rd`  in  reg_idx_t  its rd
- `flush_all`  in  1  clear all pending state; used on trap once pipeline is emptied
- `busy`  out  32  bit i = count[i] != 0; bit 0 always 0
- `idle`  out  1  all counts zero
- `stall_cycles`  out  32  saturating count of cycles with issue_valid && !issue_ready
- `underflow_err`  out  1  sticky; retire/squash to a register whose count is 0

## Operation
- State: 31 counters count[1..31], each CW bits; x0 has no counter and is never busy.
- issue_ready = !(rs1_hazard || rs2_hazard || waw_sat), where:
  - rsN_hazard = issue_rsN_used && rsN != 0 && count[rsN] != 0
  - waw_sat = issue_rd_we && rd != 0 && count[rd] == MAX_PENDING
- issue_ready depends only on registered counts and issue_* inputs. Retire or squash in the same cycle does not unblock issue; this is a deliberate one-bubble cost that removes the writeback-to-decode combinational path.
- Per-register next count = count + inc − dec_r − dec_s:
  - inc = issue fires && rd_we && rd == i
  - dec_r = retire_valid && retire_rd == i
  - dec_s = squash_valid && squash_rd == i
  - Requests naming x0 are ignored.
- Simultaneous issue and retire to the same register leave the count unchanged. A single register may receive issue, retire and squash in one cycle.
- Underflow: if the decrements exceed count + inc, the count clamps to 0 and underflow_err sets. underflow_err clears only on rst.
- flush_all: all counts go to 0 next cycle and override the same-cycle issue, retire and squash. issue_ready is forced to 0 during flush_all. stall_cycles still counts during flush_all.
- stall_cycles increments when issue_valid && !issue_ready and holds at 0xFFFF_FFFF.

## Timing
- Reset values: all counts 0, busy 0, idle 1, stall_cycles 0, underflow_err 0. issue_ready is 1 for any request once rst deasserts.
- Assertion of rst mid-operation clears everything asynchronously. In-flight retires after reset are protocol errors and set underflow_err.
- A count update is visible on busy, idle and issue_ready on the cycle after the event.
- issue_ready is combinational from issue_* inputs; the issuer must not make issue_valid depend on issue_ready.
- Latency from retire of the last producer to issue of the consumer is 1 cycle.

## Structure
- Add `localparam int NUM_REGS = 32` to core_pkg; reuse reg_idx_t.
- The scoreboard-count typedef is derived from MAX_PENDING locally.
- Sub-module `core_scoreboard_cnt` is generated ×31. It holds one saturating up/down counter with inc, dec_r, dec_s and clr inputs, and outputs nonzero, full and underflow.

## Test plan
- Reset then issue rd=5 → busy[5]=1. A consumer with rs1=5 sees issue_ready=0. Retire rd=5 at cycle T → consumer ready at T+1. stall_cycles equals the bubble count.
- Issue rd=0 with rs1=0 repeatedly → issue_ready stays 1, busy stays 0, idle stays 1.
- With MAX_PENDING=3, issue rd=7 three times → a fourth issue to rd=7 stalls. One retire → the fourth issue proceeds and count[7] returns to 3.
- count[9]=1; same-cycle issue rd=9 plus retire rd=9 → count stays 1. Same-cycle retire and squash on count[9]=2 → 0.
- Retire rd=12 with count 0 → count stays 0, underflow_err=1 and persists until rst.
- With several busy registers, assert flush_all together with an issue → all counts 0 next cycle, the issue is not recorded and not accepted. Async rst mid-stall → all outputs at reset values immediately.
